// File: rtl/led_char_scanner_pkg.sv
// Shared definitions for the 4-digit LED character scanner.
// Holds the character-code constants and two helpers: one maps codes with no
// glyph onto space, the other decodes a digit index to an active-low anode
// select.
package led_char_scanner_pkg;

    localparam int CHAR_W     = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [CHAR_W-1:0] CHAR_DASH  = 4'hA;
    localparam logic [CHAR_W-1:0] CHAR_F     = 4'hB;
    localparam logic [CHAR_W-1:0] CHAR_SPACE = 4'hC;

    // Codes above space (D..F) have no glyph and are shown as blank digits.
    function automatic logic [CHAR_W-1:0] sanitize_char(input logic [CHAR_W-1:0] code);
        logic [CHAR_W-1:0] result;
        if (code > CHAR_SPACE) begin
            result = CHAR_SPACE;
        end else begin
            result = code;
        end
        return result;
    endfunction

    // Active-low one-hot anode select; an[3] is the leftmost digit.
    function automatic logic [NUM_DIGITS-1:0] anode_decode(input logic [1:0] idx);
        logic [NUM_DIGITS-1:0] result;
        case (idx)
            2'd3:    result = 4'b0111;
            2'd2:    result = 4'b1011;
            2'd1:    result = 4'b1101;
            2'd0:    result = 4'b1110;
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/led_char_scanner_scan_tick_gen.sv
// scan_tick_gen: free-running refresh counter for the digit scan.
// Counts 0..REFRESH_CYCLES-1 and wraps; tc is high while the counter sits at
// its last value, so the edge that wraps the counter is the digit-advance edge.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   tc    out terminal-count indication (decoded from the counter register)
module scan_tick_gen #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic reset,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next counter value: wrap to zero at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE_CNT;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST_CNT);

endmodule

// File: rtl/led_char_scanner.sv
// led_char_scanner: time-multiplexed 4-digit display driver.
// Accepts 4-character messages over a valid/ready handshake into a pending
// buffer, swaps them into the active buffer only at a frame boundary (so a
// message is never shown half old, half new) and scans one digit per refresh
// slot, leftmost digit first.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   msg_valid  in  msg_data holds a message to load
//   msg_data   in  4 char codes, [15:12] = leftmost digit
//   msg_ready  out pending buffer empty; load accepted when valid & ready
//   blank      in  1 = all anodes off, scanning continues
//   char       out char code of the selected digit
//   an         out active-low anode select, an[3] = leftmost
//   digit_tick out one-cycle pulse on every digit advance
module led_char_scanner
    import led_char_scanner_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          msg_valid,
    input  logic [CHAR_W*NUM_DIGITS-1:0]  msg_data,
    output logic                          msg_ready,
    input  logic                          blank,
    output logic [CHAR_W-1:0]             char,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          digit_tick
);

    localparam logic [CHAR_W*NUM_DIGITS-1:0] BLANK_MSG = 16'hCCCC;

    logic                         tc;
    logic                         boundary;

    logic [CHAR_W*NUM_DIGITS-1:0] active_q, active_d;
    logic [CHAR_W*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                         ready_q, ready_d;
    logic [1:0]                   idx_q, idx_d;
    logic [CHAR_W-1:0]            char_q, char_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic                         tick_q, tick_d;

    scan_tick_gen #(
        .REFRESH_CYCLES (REFRESH_CYCLES),
        .CNT_W          (CNT_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tc    (tc)
    );

    // Next-state: digit index, buffer swap/handshake, registered display outputs.
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        idx_d     = idx_q;
        boundary  = tc && (idx_q == 2'd0);

        if (tc) begin
            idx_d = (idx_q == 2'd0) ? 2'd3 : (idx_q - 2'd1);
        end else begin
            idx_d = idx_q;
        end

        // A full pending buffer blocks new loads, so a swap and an accept can
        // never happen on the same edge.
        if (boundary && !ready_q) begin
            active_d = pending_q;
            ready_d  = 1'b1;
        end else if (msg_valid && ready_q) begin
            pending_d = msg_data;
            ready_d   = 1'b0;
        end else begin
            ready_d = ready_q;
        end

        // Outputs are built from the post-edge index and buffer, so the digit-3
        // char at a boundary already comes from the freshly swapped message.
        char_d = sanitize_char(active_d[{idx_d, 2'b00} +: CHAR_W]);
        if (blank) begin
            an_d = 4'b1111;
        end else begin
            an_d = anode_decode(idx_d);
        end
        tick_d = tc;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q  <= BLANK_MSG;
            pending_q <= BLANK_MSG;
            ready_q   <= 1'b1;
            idx_q     <= 2'd3;
            char_q    <= CHAR_SPACE;
            an_q      <= 4'b0111;
            tick_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            idx_q     <= idx_d;
            char_q    <= char_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
        end
    end

    assign msg_ready  = ready_q;
    assign char       = char_q;
    assign an         = an_q;
    assign digit_tick = tick_q;

endmodule

// File: tb/tb_led_char_scanner.sv
module tb_led_char_scanner;

    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        msg_valid = 1'b0;
    logic [15:0] msg_data = 16'h0000;
    logic        msg_ready;
    logic        blank = 1'b0;
    logic [3:0]  char;
    logic [3:0]  an;
    logic        digit_tick;

    int tests = 0;
    int fails = 0;

    led_char_scanner #(.REFRESH_CYCLES(R), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_data   (msg_data),
        .msg_ready  (msg_ready),
        .blank      (blank),
        .char       (char),
        .an         (an),
        .digit_tick (digit_tick)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Position is derived from the number of edges since reset release:
    // slot = k / R, digit = 3 - slot mod 4, frame boundary every 4*R edges.
    int          k;
    logic [15:0] m_active;
    logic [15:0] m_pend[$];
    logic [3:0]  exp_an;
    logic [3:0]  exp_char;
    logic        exp_ready;
    logic        exp_tick;

    function automatic logic [3:0] glyph(input logic [3:0] c);
        logic [3:0] r;
        case (c)
            4'hD, 4'hE, 4'hF: r = 4'hC;
            default:          r = c;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        k = 0;
        m_active = 16'hCCCC;
        m_pend.delete();
        exp_an = 4'b0111;
        exp_char = 4'hC;
        exp_ready = 1'b1;
        exp_tick = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic b);
        int idx;
        logic [3:0] onehot;
        k = k + 1;
        if ((k % (4 * R) == 0) && (m_pend.size() > 0)) begin
            m_active = m_pend.pop_front();
        end else if (v && (m_pend.size() == 0)) begin
            m_pend.push_back(d);
        end
        idx = 3 - ((k / R) % 4);
        onehot = 4'b0001 << idx;
        exp_an = b ? 4'b1111 : ~onehot;
        exp_char = glyph(m_active[idx*4 +: 4]);
        exp_ready = (m_pend.size() == 0);
        exp_tick = (k % R == 0);
    endtask

    // Continuous check of every cycle against the model, then advance the model
    // over the coming rising edge using the inputs that edge will sample.
    always @(negedge clk) begin
        if (!reset) model_reset();
        tests = tests + 1;
        if ({an, char, msg_ready, digit_tick} !== {exp_an, exp_char, exp_ready, exp_tick}) begin
            fails = fails + 1;
            $display("FAIL model_cycle k=%0d: got an=%b char=%h ready=%b tick=%b, expected an=%b char=%h ready=%b tick=%b",
                     k, an, char, msg_ready, digit_tick, exp_an, exp_char, exp_ready, exp_tick);
        end
        if (reset) model_step(msg_valid, msg_data, blank);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests = tests + 1;
        if (act !== expv) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Load one message: wait for ready, present it for exactly one edge.
    task automatic load(input logic [15:0] m);
        bit done;
        done = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            if (msg_ready) begin
                msg_valid = 1'b1;
                msg_data = m;
                step();
                msg_valid = 1'b0;
                chk("ready_drop_after_accept", {15'd0, msg_ready}, 16'd0);
                done = 1;
            end
        end
        if (!done) timeout("load_wait_ready");
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < R + 2 && !seen; i++) begin
            step();
            if (digit_tick) seen = 1;
        end
        if (!seen) timeout(name);
    endtask

    // Wait for the next frame start and compare all four displayed digits.
    task automatic capture_frame(input logic [15:0] expw);
        bit seen;
        logic [3:0] onehot;
        seen = 0;
        for (int i = 0; i < 8 * R + 4 && !seen; i++) begin
            step();
            if (digit_tick && an == 4'b0111) seen = 1;
        end
        if (!seen) begin
            timeout("frame_start");
        end else begin
            for (int d = 3; d >= 0; d--) begin
                if (d < 3) wait_tick("frame_digit_tick");
                onehot = 4'b0001 << d;
                chk("frame_char", {12'd0, char}, {12'd0, expw[d*4 +: 4]});
                chk("frame_an", {12'd0, an}, {12'd0, ~onehot});
            end
        end
    endtask

    typedef struct {
        logic [15:0] msg;
        logic [15:0] shown;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{msg: 16'h1234, shown: 16'h1234};
        vecs[1] = '{msg: 16'hAB0A, shown: 16'hAB0A};
        vecs[2] = '{msg: 16'hFED0, shown: 16'hCCC0};
        vecs[3] = '{msg: 16'h9E5C, shown: 16'h9C5C};
        vecs[4] = '{msg: 16'h0F70, shown: 16'h0C70};

        // 1: reset release and first digit advance
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_an", {12'd0, an}, 16'h0007);
        chk("rst_char", {12'd0, char}, 16'h000C);
        chk("rst_ready", {15'd0, msg_ready}, 16'd1);
        @(posedge clk);
        #2;
        repeat (3) step();
        chk("first_adv_an", {12'd0, an}, 16'h000B);
        chk("first_adv_tick", {15'd0, digit_tick}, 16'd1);
        step();
        chk("first_adv_tick_clear", {15'd0, digit_tick}, 16'd0);

        // 2 & 4: table-driven messages
        for (int i = 0; i < 5; i++) begin
            load(vecs[i].msg);
            capture_frame(vecs[i].shown);
            chk("ready_after_swap", {15'd0, msg_ready}, 16'd1);
        end

        // 3: held valid is blocked until the swap, accepted the cycle after
        load(16'hAB0A);
        msg_valid = 1'b1;
        msg_data = 16'h5678;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 8 * R + 4 && !seen; i++) begin
                step();
                if (msg_ready) seen = 1;
            end
            if (!seen) timeout("held_wait_swap");
        end
        chk("swap_an", {12'd0, an}, 16'h0007);
        chk("swap_char", {12'd0, char}, 16'h000A);
        step();
        chk("held_accept", {15'd0, msg_ready}, 16'd0);
        msg_valid = 1'b0;
        wait_tick("held_d2");
        chk("held_d2_char", {12'd0, char}, 16'h000B);
        wait_tick("held_d1");
        chk("held_d1_char", {12'd0, char}, 16'h0000);
        wait_tick("held_d0");
        chk("held_d0_char", {12'd0, char}, 16'h000A);
        capture_frame(16'h5678);

        // 5: blanking
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("blank_an", {12'd0, an}, 16'h000F);
        end
        blank = 1'b0;
        step();
        chk("unblank_an", {12'd0, an}, {12'd0, exp_an});

        // 6: reset with a pending message mid-digit-1
        capture_frame(16'h5678);
        load(16'h4321);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 4 * R + 4 && !seen; i++) begin
                step();
                if (an == 4'b1101) seen = 1;
            end
            if (!seen) timeout("wait_digit1");
        end
        step();
        reset = 1'b0;
        #1;
        chk("midrst_an", {12'd0, an}, 16'h0007);
        chk("midrst_char", {12'd0, char}, 16'h000C);
        chk("midrst_ready", {15'd0, msg_ready}, 16'd1);
        chk("midrst_tick", {15'd0, digit_tick}, 16'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        capture_frame(16'hCCCC);
        capture_frame(16'hCCCC);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step();
            msg_valid = ($urandom_range(0, 2) == 0);
            msg_data = $urandom();
            blank = ($urandom_range(0, 7) == 0);
        end
        step();
        msg_valid = 1'b0;
        blank = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
